alu_flag_stage: RTL
===================

ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
REQ-001 SHALL have parameter N, default 32, the datapath width of the ALU result.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  discards the held entry and the offered entry.
REQ-005 SHALL have port in_valid  input  1  upstream ALU result valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port in_result  input  N  ALU result.
REQ-008 SHALL have port in_flags  input  4  ALU flags {N,Z,C,O}, bit 3 = N.
REQ-009 SHALL have port in_setflags  input  1  instruction updates the flag register.
REQ-010 SHALL have port in_cond  input  4  condition code.
REQ-011 SHALL have port in_rd  input  4  destination register index.
REQ-012 SHALL have port in_wb_en  input  1  instruction writes rd.
REQ-013 SHALL have port out_valid, out_ready  output/input  1 each  downstream handshake.
REQ-014 SHALL have ports out_result (N), out_rd (4), out_wb_en (1)  output  registered entry.
REQ-015 SHALL have port flags  output  4  architectural flag register {N,Z,C,O}.
REQ-016 SHALL have ports exec_count, squash_count  output  16 each  saturating event counters.

Function
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational; single-entry register).
REQ-018 SHALL accept an entry on a rising edge where in_valid && in_ready && !flush.
REQ-019 SHALL evaluate in_cond against the flags register value present before the accepting edge: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS O; 7 VC !O; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==O; 11 LT N!=O; 12 GT !Z&(N==O); 13 LE Z|(N!=O); 14 AL 1; 15 NV 0.
REQ-020 SHALL on accept with pass: load out_result/out_rd, set out_wb_en = in_wb_en, and if in_setflags load flags <= in_flags on the same edge.
REQ-021 SHALL on accept with fail: load out_result/out_rd, force out_wb_en = 0, leave flags unchanged.
REQ-022 SHALL set out_valid = 1 after an accept; clear it after an edge with out_valid && out_ready and no new accept; a simultaneous drain and accept keeps it 1 with the new entry.
REQ-023 SHALL hold out_result/out_rd/out_wb_en stable while out_valid && !out_ready.
REQ-024 SHALL on flush: clear out_valid on the next edge, accept nothing, leave flags and counters unchanged; flush beats accept.
REQ-025 SHALL make back-to-back accepted entries see flags written by the previous accepted entry (1-cycle latency, no bypass from in_flags).
REQ-026 SHALL increment exec_count per passed accept and squash_count per failed accept, each saturating at 16'hFFFF.
REQ-027 SHALL keep the flag, counter and output-register updates in one clocked process; all outputs except in_ready are registered.

Reset
REQ-028 SHALL on rst=1 at a rising edge set out_valid=0, out_result=0, out_rd=0, out_wb_en=0, flags=4'b0000, exec_count=0, squash_count=0.
REQ-029 SHALL give rst priority over flush and accept; an entry offered during reset is lost; in_ready=1 in the first cycle after reset.

Verification
REQ-030 Reset then in_cond=14, in_setflags=1, in_flags=4'b0100, in_result=32'h0, out_ready=1 -> next cycle out_valid=1, out_wb_en=in_wb_en, flags=4'b0100, exec_count=1.
REQ-031 With flags=4'b0100, offer in_cond=1 (NE), in_wb_en=1, in_setflags=1, in_flags=4'b1000 -> out_wb_en=0, flags stay 4'b0100, squash_count=1.
REQ-032 Back-to-back: entry A (AL, setflags, in_flags=4'b0010), then entry B (CS, wb_en=1) next cycle -> B passes, out_wb_en=1.
REQ-033 out_ready=0 with out_valid=1, in_valid=1 -> in_ready=0, out_result stable for 5 cycles; raise out_ready -> drain and accept on the same edge, out_valid stays 1.
REQ-034 flush=1 together with in_valid=1 and out_valid=1 -> next cycle out_valid=0, flags and counters unchanged.
REQ-035 Preload: 65,537 passed accepts -> exec_count=16'hFFFF and holds there; then rst mid-stream -> all outputs return to REQ-028 values.

Source files
------------

// File: rtl/alu_flag_stage.sv
// Single-entry ALU writeback stage. It evaluates the condition code against the
// architectural flag register, squashes failed instructions and keeps event counters.
module alu_flag_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic [3:0]   in_flags,
  input  logic         in_setflags,
  input  logic [3:0]   in_cond,
  input  logic [3:0]   in_rd,
  input  logic         in_wb_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_rd,
  output logic         out_wb_en,
  output logic [3:0]   flags,
  output logic [15:0]  exec_count,
  output logic [15:0]  squash_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // ready never depends on valid from the same side, and a held entry stays stable
  // until it is taken.
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_result_q, out_result_d;
  logic [3:0]   out_rd_q, out_rd_d;
  logic         out_wb_en_q, out_wb_en_d;
  logic [3:0]   flags_q, flags_d;
  logic [15:0]  exec_q, exec_d;
  logic [15:0]  squash_q, squash_d;

  logic flag_n, flag_z, flag_c, flag_o;
  logic cond_pass;
  logic accept;
  logic drain;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_o = flags_q[0];

  // The condition is evaluated only against the committed flags, never against in_flags.
  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'd0:  cond_pass = flag_z;
      4'd1:  cond_pass = !flag_z;
      4'd2:  cond_pass = flag_c;
      4'd3:  cond_pass = !flag_c;
      4'd4:  cond_pass = flag_n;
      4'd5:  cond_pass = !flag_n;
      4'd6:  cond_pass = flag_o;
      4'd7:  cond_pass = !flag_o;
      4'd8:  cond_pass = flag_c && !flag_z;
      4'd9:  cond_pass = !flag_c || flag_z;
      4'd10: cond_pass = (flag_n == flag_o);
      4'd11: cond_pass = (flag_n != flag_o);
      4'd12: cond_pass = !flag_z && (flag_n == flag_o);
      4'd13: cond_pass = flag_z || (flag_n != flag_o);
      4'd14: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wb_en_d  = out_wb_en_q;
    flags_d      = flags_q;
    exec_d       = exec_q;
    squash_d     = squash_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = in_result;
      out_rd_d     = in_rd;
      out_wb_en_d  = in_wb_en && cond_pass;
      if (cond_pass) begin
        if (in_setflags) flags_d = in_flags;
        if (exec_q != 16'hFFFF) exec_d = exec_q + 16'd1;
      end else begin
        if (squash_q != 16'hFFFF) squash_d = squash_q + 16'd1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= 4'd0;
      out_wb_en_q  <= 1'b0;
      flags_q      <= 4'b0000;
      exec_q       <= 16'd0;
      squash_q     <= 16'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wb_en_q  <= out_wb_en_d;
      flags_q      <= flags_d;
      exec_q       <= exec_d;
      squash_q     <= squash_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_rd       = out_rd_q;
  assign out_wb_en    = out_wb_en_q;
  assign flags        = flags_q;
  assign exec_count   = exec_q;
  assign squash_count = squash_q;

endmodule
